// File: rtl/tag_pkg.sv
// Shared types for the tag issue controller: FSM encoding, block descriptor
// layout and the default tag count.
package tag_pkg;

    localparam int DEFAULT_NUM_TAG = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    typedef struct packed {
        logic reuse;
        logic bias_prev_sw;
        logic ddr_pe_sw;
        logic last;
    } blk_desc_t;

endpackage

// File: rtl/rr_tag_ptr.sv
// Round-robin tag pointer: wraps from NUM_TAG-1 back to 0 on advance; clear
// has priority so a layer always restarts at tag 0.
module rr_tag_ptr
    import tag_pkg::*;
#(
    parameter int NUM_TAG = DEFAULT_NUM_TAG,
    parameter int TAG_W   = $clog2(NUM_TAG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_advance,
    input  logic             i_clear,
    output logic [TAG_W-1:0] o_ptr
);

    logic [TAG_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (i_clear) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (r_ptr == TAG_W'(NUM_TAG - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/tag_issue_ctrl.sv
// Issues decoded compute blocks to the tag_logic array in round-robin order,
// tracks in-flight tags, flushes after the last block and pulses layer_done.
module tag_issue_ctrl
    import tag_pkg::*;
#(
    parameter int NUM_TAG = DEFAULT_NUM_TAG,
    parameter int TAG_W   = $clog2(NUM_TAG)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic               blk_reuse,
    input  logic               blk_bias_prev_sw,
    input  logic               blk_ddr_pe_sw,
    input  logic               blk_last,
    output logic [NUM_TAG-1:0] tag_req,
    input  logic [NUM_TAG-1:0] tag_ready,
    output logic               tag_reuse,
    output logic               tag_bias_prev_sw,
    output logic               tag_ddr_pe_sw,
    output logic [NUM_TAG-1:0] tag_flush,
    input  logic [NUM_TAG-1:0] tag_done,
    output logic [TAG_W-1:0]   cur_tag,
    output logic [NUM_TAG-1:0] busy,
    output logic               layer_done,
    output logic               err
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_hold_valid;
    blk_desc_t          r_hold;
    logic [NUM_TAG-1:0] r_busy;
    logic               r_err;

    logic [TAG_W-1:0]   w_cur_tag;
    logic [NUM_TAG-1:0] w_tag_req;
    logic [NUM_TAG-1:0] w_issue_vec;
    logic               w_issue;
    logic               w_accept;
    logic               w_blk_ready;
    logic               w_flush;
    logic               w_layer_done;
    logic               w_ptr_clear;

    rr_tag_ptr #(
        .NUM_TAG (NUM_TAG),
        .TAG_W   (TAG_W)
    ) u_ptr (
        .clk       (clk),
        .reset     (reset),
        .i_advance (w_issue),
        .i_clear   (w_ptr_clear),
        .o_ptr     (w_cur_tag)
    );

    // Request comes only from registers, so tag_ready never loops back into tag_req.
    always_comb begin
        w_tag_req            = '0;
        w_tag_req[w_cur_tag] = r_hold_valid;
    end

    assign w_issue     = r_hold_valid && tag_ready[w_cur_tag];
    assign w_issue_vec = w_issue ? w_tag_req : '0;
    assign w_accept    = blk_valid && w_blk_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_blk_ready  = 1'b0;
        w_flush      = 1'b0;
        w_layer_done = 1'b0;
        w_ptr_clear  = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_next = RUN;
            end
            RUN: begin
                w_blk_ready = !r_hold_valid || w_issue;
                if (w_issue && r_hold.last) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                w_flush = 1'b1;
                if (r_busy == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_layer_done = 1'b1;
                w_ptr_clear  = 1'b1;
                w_state_next = RUN;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // A slot refilled in the same cycle it issues stays valid, giving one block per cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_valid <= 1'b0;
            r_hold       <= '0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold       <= {blk_reuse, blk_bias_prev_sw, blk_ddr_pe_sw, blk_last};
        end else if (w_issue) begin
            r_hold_valid <= 1'b0;
        end
    end

    // A new issue to a tag outranks its done pulse in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= w_issue_vec | (r_busy & ~tag_done);
            r_err  <= r_err | (|(tag_done & ~r_busy));
        end
    end

    assign blk_ready        = w_blk_ready;
    assign tag_req          = w_tag_req;
    assign tag_reuse        = r_hold.reuse;
    assign tag_bias_prev_sw = r_hold.bias_prev_sw;
    assign tag_ddr_pe_sw    = r_hold.ddr_pe_sw;
    assign tag_flush        = {NUM_TAG{w_flush}};
    assign cur_tag          = w_cur_tag;
    assign busy             = r_busy;
    assign layer_done       = w_layer_done;
    assign err              = r_err;

endmodule

// File: tb/tb_tag_issue_ctrl.sv
// Directed bench for tag_issue_ctrl with NUM_TAG=2: issue, backpressure,
// flush/layer completion, simultaneous done+issue, spurious done, mid-layer reset.
module tb_tag_issue_ctrl;

    logic       clk;
    logic       resetN;
    logic       blkValid;
    logic       blkReady;
    logic       blkReuse;
    logic       blkBias;
    logic       blkDdr;
    logic       blkLast;
    logic [1:0] tagReq;
    logic [1:0] tagReady;
    logic       tagReuse;
    logic       tagBias;
    logic       tagDdr;
    logic [1:0] tagFlush;
    logic [1:0] tagDone;
    logic [0:0] curTag;
    logic [1:0] busy;
    logic       layerDone;
    logic       err;

    int nCompared = 0;
    int nMismatch = 0;

    tag_issue_ctrl #(
        .NUM_TAG (2),
        .TAG_W   (1)
    ) dut (
        .clk              (clk),
        .reset            (resetN),
        .blk_valid        (blkValid),
        .blk_ready        (blkReady),
        .blk_reuse        (blkReuse),
        .blk_bias_prev_sw (blkBias),
        .blk_ddr_pe_sw    (blkDdr),
        .blk_last         (blkLast),
        .tag_req          (tagReq),
        .tag_ready        (tagReady),
        .tag_reuse        (tagReuse),
        .tag_bias_prev_sw (tagBias),
        .tag_ddr_pe_sw    (tagDdr),
        .tag_flush        (tagFlush),
        .tag_done         (tagDone),
        .cur_tag          (curTag),
        .busy             (busy),
        .layer_done       (layerDone),
        .err              (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Descriptor argument packs {reuse, bias_prev_sw, ddr_pe_sw, last}.
    task automatic applyStimulus(input logic valid, input logic [3:0] desc,
                                 input logic [1:0] ready, input logic [1:0] done);
        blkValid = valid;
        {blkReuse, blkBias, blkDdr, blkLast} = desc;
        tagReady = ready;
        tagDone  = done;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatch++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0;
        applyStimulus(1'b0, 4'b0000, 2'b00, 2'b00);
        tick();
        tick();

        checkOutput("rst_blk_ready", 32'(blkReady), 32'd0);
        checkOutput("rst_tag_req", 32'(tagReq), 32'd0);
        checkOutput("rst_fields", 32'({tagReuse, tagBias, tagDdr}), 32'd0);
        checkOutput("rst_tag_flush", 32'(tagFlush), 32'd0);
        checkOutput("rst_cur_tag", 32'(curTag), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_layer_done", 32'(layerDone), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);

        resetN = 1'b1;
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("idle_blk_ready", 32'(blkReady), 32'd0);
        tick();

        $display("[TB] basic issue");
        applyStimulus(1'b1, 4'b1000, 2'b11, 2'b00);
        checkOutput("c0_blk_ready", 32'(blkReady), 32'd1);
        checkOutput("c0_tag_req", 32'(tagReq), 32'd0);
        tick();
        applyStimulus(1'b1, 4'b0100, 2'b11, 2'b00);
        checkOutput("c1_tag_req", 32'(tagReq), 32'h1);
        checkOutput("c1_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h4);
        checkOutput("c1_blk_ready", 32'(blkReady), 32'd1);
        checkOutput("c1_busy", 32'(busy), 32'h0);
        tick();
        applyStimulus(1'b1, 4'b0010, 2'b11, 2'b00);
        checkOutput("c2_tag_req", 32'(tagReq), 32'h2);
        checkOutput("c2_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h2);
        checkOutput("c2_busy", 32'(busy), 32'h1);
        checkOutput("c2_cur_tag", 32'(curTag), 32'd1);
        checkOutput("c2_blk_ready", 32'(blkReady), 32'd1);
        tick();
        applyStimulus(1'b1, 4'b1100, 2'b11, 2'b00);
        checkOutput("c3_tag_req", 32'(tagReq), 32'h1);
        checkOutput("c3_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h1);
        checkOutput("c3_busy", 32'(busy), 32'h3);
        checkOutput("c3_blk_ready", 32'(blkReady), 32'd1);
        tick();
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("c4_tag_req", 32'(tagReq), 32'h2);
        checkOutput("c4_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h6);
        tick();
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b11);
        checkOutput("c5_tag_req", 32'(tagReq), 32'h0);
        checkOutput("c5_cur_tag", 32'(curTag), 32'd0);
        checkOutput("c5_busy", 32'(busy), 32'h3);
        tick();

        $display("[TB] backpressure");
        applyStimulus(1'b1, 4'b1010, 2'b01, 2'b00);
        checkOutput("c6_busy", 32'(busy), 32'h0);
        checkOutput("c6_err", 32'(err), 32'd0);
        checkOutput("c6_blk_ready", 32'(blkReady), 32'd1);
        tick();
        applyStimulus(1'b1, 4'b0110, 2'b01, 2'b00);
        checkOutput("c7_tag_req", 32'(tagReq), 32'h1);
        checkOutput("c7_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h5);
        checkOutput("c7_blk_ready", 32'(blkReady), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'b1100, 2'b01, 2'b00);
            checkOutput("stall_tag_req", 32'(tagReq), 32'h2);
            checkOutput("stall_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h3);
            checkOutput("stall_blk_ready", 32'(blkReady), 32'd0);
            checkOutput("stall_cur_tag", 32'(curTag), 32'd1);
            tick();
        end
        applyStimulus(1'b1, 4'b1100, 2'b11, 2'b00);
        checkOutput("c11_tag_req", 32'(tagReq), 32'h2);
        checkOutput("c11_blk_ready", 32'(blkReady), 32'd1);
        tick();
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("c12_tag_req", 32'(tagReq), 32'h1);
        checkOutput("c12_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h6);
        checkOutput("c12_cur_tag", 32'(curTag), 32'd0);
        tick();

        $display("[TB] simultaneous done and issue");
        applyStimulus(1'b1, 4'b0010, 2'b11, 2'b00);
        checkOutput("c13_tag_req", 32'(tagReq), 32'h0);
        checkOutput("c13_cur_tag", 32'(curTag), 32'd1);
        checkOutput("c13_busy", 32'(busy), 32'h3);
        tick();
        applyStimulus(1'b1, 4'b1000, 2'b11, 2'b00);
        checkOutput("c14_tag_req", 32'(tagReq), 32'h2);
        checkOutput("c14_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h1);
        tick();
        applyStimulus(1'b1, 4'b0100, 2'b11, 2'b01);
        checkOutput("c15_tag_req", 32'(tagReq), 32'h1);
        checkOutput("c15_cur_tag", 32'(curTag), 32'd0);
        checkOutput("c15_busy", 32'(busy), 32'h3);
        tick();
        applyStimulus(1'b1, 4'b1001, 2'b11, 2'b00);
        checkOutput("sim_busy", 32'(busy), 32'h3);
        checkOutput("sim_err", 32'(err), 32'd0);
        checkOutput("c16_tag_req", 32'(tagReq), 32'h2);
        tick();

        $display("[TB] flush");
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("last_tag_req", 32'(tagReq), 32'h1);
        checkOutput("last_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h4);
        checkOutput("last_busy", 32'(busy), 32'h3);
        checkOutput("last_tag_flush", 32'(tagFlush), 32'h0);
        tick();
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("fl1_cur_tag", 32'(curTag), 32'd1);
        checkOutput("fl1_blk_ready", 32'(blkReady), 32'd0);
        checkOutput("fl1_tag_req", 32'(tagReq), 32'h0);
        checkOutput("fl1_busy", 32'(busy), 32'h3);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin
                applyStimulus(1'b0, 4'b0000, 2'b11,
                              (k == 2) ? 2'b01 : ((k == 5) ? 2'b10 : 2'b00));
            end
            checkOutput("fl_tag_flush", 32'(tagFlush), 32'h3);
            checkOutput("fl_layer_done", 32'(layerDone), 32'd0);
            if (k == 3) checkOutput("fl3_busy", 32'(busy), 32'h2);
            if (k == 6) checkOutput("fl6_busy", 32'(busy), 32'h0);
            tick();
        end
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("done_layer_done", 32'(layerDone), 32'd1);
        checkOutput("done_tag_flush", 32'(tagFlush), 32'h0);
        checkOutput("done_blk_ready", 32'(blkReady), 32'd0);
        tick();

        $display("[TB] spurious done");
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b10);
        checkOutput("post_layer_done", 32'(layerDone), 32'd0);
        checkOutput("post_cur_tag", 32'(curTag), 32'd0);
        checkOutput("post_blk_ready", 32'(blkReady), 32'd1);
        checkOutput("post_err", 32'(err), 32'd0);
        tick();
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("spur_err", 32'(err), 32'd1);
        checkOutput("spur_busy", 32'(busy), 32'h0);
        checkOutput("spur_blk_ready", 32'(blkReady), 32'd1);
        tick();

        $display("[TB] reset mid-layer");
        applyStimulus(1'b1, 4'b0101, 2'b11, 2'b00);
        checkOutput("sticky_err", 32'(err), 32'd1);
        tick();
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("h_tag_req", 32'(tagReq), 32'h1);
        checkOutput("h_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h2);
        tick();
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("h_tag_flush", 32'(tagFlush), 32'h3);
        checkOutput("h_busy", 32'(busy), 32'h1);
        checkOutput("h_cur_tag", 32'(curTag), 32'd1);
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("ar_tag_flush", 32'(tagFlush), 32'h0);
        checkOutput("ar_busy", 32'(busy), 32'h0);
        checkOutput("ar_cur_tag", 32'(curTag), 32'd0);
        checkOutput("ar_err", 32'(err), 32'd0);
        checkOutput("ar_blk_ready", 32'(blkReady), 32'd0);
        checkOutput("ar_tag_req", 32'(tagReq), 32'h0);
        checkOutput("ar_fields", 32'({tagReuse, tagBias, tagDdr}), 32'h0);
        checkOutput("ar_layer_done", 32'(layerDone), 32'd0);
        tick();
        resetN = 1'b1;
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("rel_idle_blk_ready", 32'(blkReady), 32'd0);
        tick();
        applyStimulus(1'b0, 4'b0000, 2'b11, 2'b00);
        checkOutput("rel_run_blk_ready", 32'(blkReady), 32'd1);
        checkOutput("rel_tag_flush", 32'(tagFlush), 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
